// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU frame sequencer: FSM state encoding and
//   the opcode constants understood by the companion ALU.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } seq_state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;

endpackage

// File: rtl/seq_timeout_timer.sv
// ----------------------------------------------------------------------------
// seq_timeout_timer
//   Inter-byte timeout counter for the frame sequencer.
//   Ports:
//     i_clk, i_rst_n  clock / async active-low reset
//     i_clear         synchronous clear (has priority over i_enable)
//     i_enable        count one clock
//     o_expire        high while the count equals TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module seq_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int NB_T = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_T-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == NB_T'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_frame_sequencer.sv
// ----------------------------------------------------------------------------
// alu_frame_sequencer
//   Pops three bytes per frame from the RX FIFO (A, B, opcode), presents them
//   to a combinational ALU, captures the result and pushes it to the TX FIFO.
//   Ports:
//     i_clk, i_rst_n              clock / async active-low reset
//     i_rx_empty, i_rx_data       RX FIFO (first-word fall-through)
//     o_rx_read                   RX pop strobe
//     o_alu_a, o_alu_b, o_alu_op  registered ALU operands
//     i_alu_result                ALU result
//     i_tx_full                   TX FIFO full flag
//     o_tx_write, o_tx_data       TX push strobe / registered result byte
//     o_busy                      high outside GET_A
//     o_frame_count               completed frames (wrapping)
//     o_timeout                   one-cycle pulse on frame abort
//   Optional feature: define ALU_SEQ_TIMEOUT_EN to enable the inter-byte
//   timeout in GET_B/GET_OP.
// ----------------------------------------------------------------------------
module alu_frame_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_CNT         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rx_read,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_full,
    output logic               o_tx_write,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic [NB_CNT-1:0]  o_frame_count,
    output logic               o_timeout
);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic [NB_CNT-1:0]  r_frame_count;
    logic               w_in_get;
    logic               w_mid_frame;
    logic               w_abort;

    assign w_in_get    = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);
    assign w_mid_frame = (r_state == GET_B) || (r_state == GET_OP);

`ifdef ALU_SEQ_TIMEOUT_EN
    logic w_expire;

    // Timer runs only while waiting for B/opcode; any accepted byte restarts it.
    seq_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (!w_mid_frame || !i_rx_empty),
        .i_enable (w_mid_frame),
        .o_expire (w_expire)
    );

    assign w_abort = w_mid_frame && i_rx_empty && w_expire;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES >= 2) && w_mid_frame;
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GET_A:   if (!i_rx_empty) w_state_next = GET_B;
            GET_B:   if (!i_rx_empty) w_state_next = GET_OP;
                     else if (w_abort) w_state_next = GET_A;
            GET_OP:  if (!i_rx_empty) w_state_next = EXEC;
                     else if (w_abort) w_state_next = GET_A;
            EXEC:    w_state_next = SEND;
            SEND:    if (!i_tx_full) w_state_next = GET_A;
            default: w_state_next = GET_A;
        endcase
    end

    // Output strobes; gated by reset so nothing pops/pushes while held in reset
    always_comb begin
        o_rx_read  = i_rst_n && w_in_get && !i_rx_empty;
        o_tx_write = i_rst_n && (r_state == SEND) && !i_tx_full;
        o_busy     = (r_state != GET_A);
        o_timeout  = i_rst_n && w_abort;
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_tx_data     <= '0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                GET_A:  if (!i_rx_empty) r_alu_a  <= i_rx_data;
                GET_B:  if (!i_rx_empty) r_alu_b  <= i_rx_data;
                GET_OP: if (!i_rx_empty) r_alu_op <= i_rx_data[NB_OP-1:0];
                EXEC:   r_tx_data <= i_alu_result;
                SEND:   if (!i_tx_full) r_frame_count <= r_frame_count + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign o_tx_data     = r_tx_data;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_frame_sequencer
//   Wraps the sequencer with a small RX FIFO model, a TX write logger and a
//   reference ALU. Table-driven frames plus hand-written corner sequences.
// ----------------------------------------------------------------------------
module tb_alu_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic [7:0]  alu_a, alu_b, alu_res, tx_data;
    logic [5:0]  alu_op;
    logic        tx_full = 1'b0;
    logic        tx_write;
    logic        busy;
    logic [15:0] frame_count;
    logic        timeout;

    always #5 clk = ~clk;

    alu_frame_sequencer #(
        .NB_DATA(8),
        .NB_OP(6),
        .NB_CNT(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_empty    (rx_empty),
        .i_rx_data     (rx_data),
        .o_rx_read     (rx_read),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_op      (alu_op),
        .i_alu_result  (alu_res),
        .i_tx_full     (tx_full),
        .o_tx_write    (tx_write),
        .o_tx_data     (tx_data),
        .o_busy        (busy),
        .o_frame_count (frame_count),
        .o_timeout     (timeout)
    );

    // Reference ALU
    always_comb begin
        case (alu_op)
            6'h20:   alu_res = alu_a + alu_b;
            6'h22:   alu_res = alu_a - alu_b;
            6'h24:   alu_res = alu_a & alu_b;
            6'h25:   alu_res = alu_a | alu_b;
            default: alu_res = 8'h00;
        endcase
    end

    // RX FIFO model (first-word fall-through)
    logic [7:0] rx_mem [0:15];
    logic [4:0] rx_wp = '0;
    logic [4:0] rx_rp = '0;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_data  = rx_mem[rx_rp[3:0]];

    // Strobes sampled on the falling edge, acted on at the next rising edge
    logic       rd_q = 1'b0, wr_q = 1'b0;
    logic [7:0] txd_q = '0;
    int         cyc = 0, pop_cnt = 0, tx_cnt = 0, to_cnt = 0;
    int         pop_cyc [0:127];
    int         tx_cyc  [0:127];
    logic [7:0] tx_val  [0:127];

    always @(negedge clk) begin
        rd_q  <= rx_read;
        wr_q  <= tx_write;
        txd_q <= tx_data;
        if (timeout) to_cnt <= to_cnt + 1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_q) begin
            rx_rp            <= rx_rp + 1'b1;
            pop_cyc[pop_cnt] <= cyc;
            pop_cnt          <= pop_cnt + 1;
        end
        if (wr_q) begin
            tx_val[tx_cnt] <= txd_q;
            tx_cyc[tx_cnt] <= cyc;
            tx_cnt         <= tx_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        rx_mem[rx_wp[3:0]] = d;
        rx_wp = rx_wp + 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int target, input string nm);
        int k = 0;
        while (tx_cnt < target && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(nm, tx_cnt, target);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t vt [7];

    initial begin
        int base, pb, bad, exp_frames, exp_to;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, pb, bad, exp_frames, exp_to;
        exp_frames = 0;
        exp_to     = 0;
        for (int i = 0; i < 16; i++) rx_mem[i] = '0;

        vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vt[1] = '{8'h0F, 8'h01, 8'h22, 8'h0E};
        vt[2] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
        vt[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        vt[4] = '{8'hFF, 8'h02, 8'h20, 8'h01};
        vt[5] = '{8'h01, 8'h02, 8'h22, 8'hFF};
        vt[6] = '{8'hAA, 8'h55, 8'hE4, 8'h00};  // upper opcode bits ignored -> AND

        // Reset with empty RX
        tick(3);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst frame_count", frame_count, 0);
        chk("rst strobes/busy", {busy, rx_read, tx_write, timeout}, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle busy", busy, 0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            base = tx_cnt;
            push(vt[i].a);
            push(vt[i].b);
            push(vt[i].op);
            exp_frames++;
            wait_tx(base + 1, $sformatf("vec%0d tx count", i));
            chk($sformatf("vec%0d alu_a", i), alu_a, vt[i].a);
            chk($sformatf("vec%0d alu_b", i), alu_b, vt[i].b);
            chk($sformatf("vec%0d alu_op", i), alu_op, vt[i].op & 8'h3F);
            chk($sformatf("vec%0d tx data", i), tx_val[base], vt[i].res);
            chk($sformatf("vec%0d frame_count", i), frame_count, exp_frames);
            tick(1);
        end

        // TX full held during SEND
        base = tx_cnt;
        tx_full = 1'b1;
        push(8'h0F); push(8'h01); push(8'h20);
        tick(4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_write || !busy || rx_read || tx_data !== 8'h10 || tx_cnt != base) bad++;
            tick(1);
        end
        chk("full hold violations", bad, 0);
        chk("full hold frame_count", frame_count, exp_frames);
        tx_full = 1'b0;
        exp_frames++;
        wait_tx(base + 1, "full release tx count");
        tick(3);
        chk("full release single write", tx_cnt, base + 1);
        chk("full release data", tx_val[base], 8'h10);
        chk("full release frame_count", frame_count, exp_frames);

        // Two preloaded frames back to back
        base = tx_cnt;
        pb   = pop_cnt;
        push(8'h05); push(8'h03); push(8'h20);
        push(8'h0F); push(8'h01); push(8'h22);
        exp_frames += 2;
        wait_tx(base + 2, "b2b tx count");
        chk("b2b data0", tx_val[base], 8'h08);
        chk("b2b data1", tx_val[base+1], 8'h0E);
        chk("b2b latency0", tx_cyc[base] - pop_cyc[pb], 4);
        chk("b2b latency1", tx_cyc[base+1] - pop_cyc[pb], 9);
        chk("b2b frame_count", frame_count, exp_frames);

        // Reset in the middle of a frame
        tick(2);
        push(8'h09); push(8'h07);
        tick(3);
        chk("mid alu_a", alu_a, 8'h09);
        chk("mid alu_b", alu_b, 8'h07);
        chk("mid busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst regs", {alu_a, alu_b, 2'b00, alu_op, tx_data}, 0);
        chk("async rst frame_count", frame_count, 0);
        chk("async rst busy", busy, 0);
        exp_frames = 0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        base = tx_cnt;
        push(8'h02); push(8'h02); push(8'h20);
        exp_frames++;
        wait_tx(base + 1, "post-rst tx count");
        chk("post-rst data", tx_val[base], 8'h04);
        chk("post-rst frame_count", frame_count, exp_frames);

        // Lone A byte: timeout abort or indefinite wait
        tick(2);
        base = tx_cnt;
        push(8'h07);
        tick(40);
`ifdef ALU_SEQ_TIMEOUT_EN
        exp_to = 1;
        chk("timeout pulses", to_cnt, 1);
        chk("timeout no write", tx_cnt, base);
        chk("timeout back to idle", busy, 0);
        chk("timeout frame_count", frame_count, exp_frames);
        push(8'h01); push(8'h01); push(8'h20);
        exp_frames++;
        wait_tx(base + 1, "after timeout tx count");
        chk("after timeout data", tx_val[base], 8'h02);
`else
        chk("wait no timeout", to_cnt, 0);
        chk("wait no write", tx_cnt, base);
        chk("wait still busy", busy, 1);
        push(8'h01); push(8'h20);
        exp_frames++;
        wait_tx(base + 1, "after wait tx count");
        chk("after wait data", tx_val[base], 8'h08);
`endif
        chk("final frame_count", frame_count, exp_frames);
        tick(5);
        chk("final timeout count", to_cnt, exp_to);
        chk("final tx count", tx_cnt, base + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
